// File: rtl/pressure_scan_controller_pkg.sv
// Shared types and sizing helpers for the pressure scan controller.
// The scan FSM and the per-channel persistence counters both import this package.
package pressure_scan_controller_pkg;

    localparam int PRESSURE_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    function automatic int count_width(input int persist);
        return $clog2(persist + 1);
    endfunction

endpackage

// File: rtl/abnormality_persist_counter.sv
// Per-channel saturating persistence count and sticky alarm.
// On an update where the count reaches PERSIST, the set wins over a simultaneous ack.
module abnormality_persist_counter
    import pressure_scan_controller_pkg::*;
#(
    parameter int PERSIST = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_update,
    input  logic i_abnormal,
    input  logic i_enabled,
    input  logic i_ack,
    output logic o_alarm
);

    localparam int CW = count_width(PERSIST);
    localparam logic [CW-1:0] SAT = CW'(PERSIST);

    logic [CW-1:0] r_count;
    logic          r_alarm;
    logic [CW-1:0] w_count_next;
    logic          w_set;

    always_comb begin
        w_count_next = r_count;
        if (i_update) begin
            if (i_enabled && i_abnormal)
                w_count_next = (r_count == SAT) ? SAT : r_count + 1'b1;
            else
                w_count_next = '0;
        end
    end

    // A count already saturated at PERSIST re-asserts the alarm on every abnormal scan.
    assign w_set = i_update && i_enabled && i_abnormal && (w_count_next == SAT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_set)
                r_alarm <= 1'b1;
            else if (i_ack)
                r_alarm <= 1'b0;
        end
    end

    assign o_alarm = r_alarm;

endmodule

// File: rtl/pressure_scan_controller.sv
// Round-robin scan of CHANNELS pressure samples through one shared abnormality detector,
// with per-channel persistence counting and sticky, acknowledgeable alarms.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a scan request; outputs hold
// ST_LOAD  | register channel sample onto the detector input
// ST_CHECK | detector result stable; update channel count, advance
// ST_DONE  | one-cycle scan-complete pulse, return to channel 0
module pressure_scan_controller
    import pressure_scan_controller_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int PERSIST  = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_scan_start,
    input  logic [CHANNELS-1:0]            i_chan_enable,
    input  logic [CHANNELS*PRESSURE_W-1:0] i_pressure_bus,
    output logic [PRESSURE_W-1:0]          o_det_pressure,
    input  logic                           i_det_abnormal,
    input  logic [CHANNELS-1:0]            i_alarm_ack,
    output logic [CHANNELS-1:0]            o_alarm,
    output logic                           o_alarm_any,
    output logic                           o_busy,
    output logic                           o_scan_done,
    output logic [$clog2(CHANNELS)-1:0]    o_cur_channel
);

    localparam int CHW = $clog2(CHANNELS);
    localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);

    scan_state_t           r_state;
    logic [CHW-1:0]        r_cur_channel;
    logic [PRESSURE_W-1:0] r_det_pressure;
    logic                  r_busy;
    logic                  r_scan_done;
    logic                  r_alarm_any;

    logic [PRESSURE_W-1:0] w_sample;
    logic [CHANNELS-1:0]   w_update;
    logic [CHANNELS-1:0]   w_alarm;

    assign w_sample = i_pressure_bus[int'(r_cur_channel)*PRESSURE_W +: PRESSURE_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_cur_channel  <= '0;
            r_det_pressure <= '0;
            r_busy         <= 1'b0;
            r_scan_done    <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_scan_start) begin
                        r_state       <= ST_LOAD;
                        r_cur_channel <= '0;
                        r_busy        <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_det_pressure <= w_sample;
                    r_state        <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (r_cur_channel == LAST_CH) begin
                        r_state     <= ST_DONE;
                        r_scan_done <= 1'b1;
                    end else begin
                        r_cur_channel <= r_cur_channel + 1'b1;
                        r_state       <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_cur_channel <= '0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign w_update[gi] = (r_state == ST_CHECK) && (r_cur_channel == CHW'(gi));

        abnormality_persist_counter #(
            .PERSIST (PERSIST)
        ) u_persist (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_update   (w_update[gi]),
            .i_abnormal (i_det_abnormal),
            .i_enabled  (i_chan_enable[gi]),
            .i_ack      (i_alarm_ack[gi]),
            .o_alarm    (w_alarm[gi])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_alarm_any <= 1'b0;
        else
            r_alarm_any <= |w_alarm;
    end

    assign o_det_pressure = r_det_pressure;
    assign o_alarm        = w_alarm;
    assign o_alarm_any    = r_alarm_any;
    assign o_busy         = r_busy;
    assign o_scan_done    = r_scan_done;
    assign o_cur_channel  = r_cur_channel;

endmodule

// File: tb/tb_pressure_scan_controller.sv
// Directed bench for pressure_scan_controller with CHANNELS=4, PERSIST=3 and a
// window-comparator detector stub (abnormal below 8 or above 38).
module tb_pressure_scan_controller;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_start = 1'b0;
    logic [CH-1:0] chan_enable = 4'b1111;
    logic [23:0]   pressure_bus = '0;
    logic [5:0]    det_pressure;
    logic          det_abnormal;
    logic [CH-1:0] alarm_ack = '0;
    logic [CH-1:0] alarm;
    logic          alarm_any;
    logic          busy;
    logic          scan_done;
    logic [1:0]    cur_channel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign det_abnormal = (det_pressure < 6'd8) || (det_pressure > 6'd38);

    pressure_scan_controller #(.CHANNELS(4), .PERSIST(3)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_scan_start   (scan_start),
        .i_chan_enable  (chan_enable),
        .i_pressure_bus (pressure_bus),
        .o_det_pressure (det_pressure),
        .i_det_abnormal (det_abnormal),
        .i_alarm_ack    (alarm_ack),
        .o_alarm        (alarm),
        .o_alarm_any    (alarm_any),
        .o_busy         (busy),
        .o_scan_done    (scan_done),
        .o_cur_channel  (cur_channel)
    );

    function automatic logic [23:0] bus4(input logic [5:0] p3, p2, p1, p0);
        return {p3, p2, p1, p0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        scan_start = 1'b0;
        alarm_ack = '0;
        chan_enable = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Ends in the IDLE cycle right after DONE (cycle 10).
    task automatic run_scan();
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || scan_done !== 1'b0 || alarm !== 4'b0000 || alarm_any !== 1'b0 ||
            cur_channel !== 2'd0 || det_pressure !== 6'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b alarm=%b any=%b cur=%0d det=%0d expected all zero",
                     busy, scan_done, alarm, alarm_any, cur_channel, det_pressure);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal_scan();
        logic       exp_busy, exp_done;
        logic [1:0] exp_cur;
        pressure_bus = bus4(6'd20, 6'd20, 6'd20, 6'd20);
        @(negedge clk);
        scan_start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            scan_start = 1'b0;
            exp_busy = (cyc <= 9);
            exp_done = (cyc == 9);
            exp_cur  = (cyc >= 10) ? 2'd0 : (cyc == 9) ? 2'd3 : 2'((cyc - 1) / 2);
            checks++;
            if (busy !== exp_busy || scan_done !== exp_done || cur_channel !== exp_cur) begin
                failures++;
                $display("FAIL normal_scan cyc=%0d busy=%b done=%b cur=%0d expected busy=%b done=%b cur=%0d",
                         cyc, busy, scan_done, cur_channel, exp_busy, exp_done, exp_cur);
            end
        end
        checks++;
        if (alarm !== 4'b0000) begin
            failures++;
            $display("FAIL normal_alarm alarm=%b expected 0000", alarm);
        end
    endtask

    task automatic test_alarm_raise();
        logic [3:0] exp_alarm;
        logic       exp_any;
        do_reset();
        pressure_bus = bus4(6'd20, 6'd40, 6'd20, 6'd20);
        for (int s = 0; s < 2; s++) begin
            run_scan();
            checks++;
            if (alarm !== 4'b0000) begin
                failures++;
                $display("FAIL alarm_early scan=%0d alarm=%b expected 0000", s + 1, alarm);
            end
        end
        @(negedge clk);
        scan_start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            scan_start = 1'b0;
            exp_alarm = (cyc >= 7) ? 4'b0100 : 4'b0000;
            exp_any   = (cyc >= 8);
            checks++;
            if (alarm !== exp_alarm || alarm_any !== exp_any) begin
                failures++;
                $display("FAIL alarm_raise cyc=%0d alarm=%b any=%b expected alarm=%b any=%b",
                         cyc, alarm, alarm_any, exp_alarm, exp_any);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_count_reset();
        logic [5:0] seq [5] = '{6'd40, 6'd40, 6'd20, 6'd40, 6'd40};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            pressure_bus = bus4(6'd20, seq[s], 6'd20, 6'd20);
            run_scan();
            checks++;
            if (alarm !== 4'b0000) begin
                failures++;
                $display("FAIL count_reset scan=%0d alarm=%b expected 0000", s + 1, alarm);
            end
        end
    endtask

    task automatic test_ack_priority();
        do_reset();
        pressure_bus = bus4(6'd20, 6'd40, 6'd20, 6'd20);
        repeat (3) run_scan();
        checks++;
        if (alarm !== 4'b0100) begin
            failures++;
            $display("FAIL ack_setup alarm=%b expected 0100", alarm);
        end
        @(negedge clk);
        scan_start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            scan_start = 1'b0;
            alarm_ack = (cyc == 6) ? 4'b0100 : 4'b0000;
            if (cyc == 7) begin
                checks++;
                if (alarm !== 4'b0100) begin
                    failures++;
                    $display("FAIL ack_vs_set alarm=%b expected 0100", alarm);
                end
            end
        end
        alarm_ack = '0;
        @(negedge clk);
        alarm_ack = 4'b0100;
        @(negedge clk);
        alarm_ack = 4'b0000;
        checks++;
        if (alarm !== 4'b0000) begin
            failures++;
            $display("FAIL ack_idle alarm=%b expected 0000", alarm);
        end
        @(negedge clk);
        checks++;
        if (alarm_any !== 1'b0) begin
            failures++;
            $display("FAIL ack_any alarm_any=%b expected 0", alarm_any);
        end
        // Count is still saturated, so the next abnormal scan re-raises the alarm.
        run_scan();
        checks++;
        if (alarm !== 4'b0100) begin
            failures++;
            $display("FAIL resaturate alarm=%b expected 0100", alarm);
        end
    endtask

    task automatic test_disabled();
        do_reset();
        chan_enable = 4'b1011;
        pressure_bus = bus4(6'd20, 6'd63, 6'd20, 6'd20);
        @(negedge clk);
        scan_start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            scan_start = 1'b0;
            if (cyc == 6) begin
                checks++;
                if (det_pressure !== 6'd63) begin
                    failures++;
                    $display("FAIL disabled_det det=%0d expected 63", det_pressure);
                end
            end
        end
        repeat (4) run_scan();
        checks++;
        if (alarm !== 4'b0000) begin
            failures++;
            $display("FAIL disabled_alarm alarm=%b expected 0000", alarm);
        end
        chan_enable = 4'b1111;
    endtask

    task automatic test_reset_mid_scan();
        bit saw_done = 1'b0;
        do_reset();
        pressure_bus = bus4(6'd20, 6'd40, 6'd20, 6'd20);
        repeat (3) run_scan();
        @(negedge clk);
        scan_start = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || scan_done !== 1'b0 || alarm !== 4'b0000 || cur_channel !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset busy=%b done=%b alarm=%b cur=%0d expected 0 0 0000 0",
                     busy, scan_done, alarm, cur_channel);
        end
        repeat (2) begin
            @(negedge clk);
            if (scan_done !== 1'b0) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        checks++;
        if (saw_done !== 1'b0 || busy !== 1'b1 || cur_channel !== 2'd0) begin
            failures++;
            $display("FAIL restart saw_done=%b busy=%b cur=%0d expected 0 1 0", saw_done, busy, cur_channel);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (alarm !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL count_cleared alarm=%b busy=%b expected 0000 0", alarm, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pressure_bus = bus4(6'd20, 6'd20, 6'd20, 6'd20);
        @(negedge clk);
        scan_start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            if (cyc == 9 || cyc == 10 || cyc == 11) begin
                checks++;
                if (busy !== (cyc != 10) || scan_done !== (cyc == 9)) begin
                    failures++;
                    $display("FAIL back_to_back cyc=%0d busy=%b done=%b expected busy=%b done=%b",
                             cyc, busy, scan_done, (cyc != 10), (cyc == 9));
                end
            end
        end
        scan_start = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_normal_scan();
        test_alarm_raise();
        test_count_reset();
        test_ack_priority();
        test_disabled();
        test_reset_mid_scan();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
